// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg
//   Shared types and defaults for the HI/LO unit.
//   - DEF_WIDTH   : default operand and HI/LO width
//   - DEF_TIMEOUT : default watchdog limit in cycles (HILO_TIMEOUT_EN builds)
//   - st_t        : control FSM state encoding
// -----------------------------------------------------------------------------
package hilo_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_WAIT = 2'd1,
      DIV_WAIT = 2'd2
   } st_t;

endpackage

// File: rtl/hilo_if.sv
// -----------------------------------------------------------------------------
// hilo_if
//   Bus between the HI/LO unit and its arithmetic engines (Booth multiplier and
//   divider). Both engines share the MultA/MultB operand registers.
//   Handshake: MultControl / DivStart are one-cycle launch pulses from the
//   master; the engine answers with a one-cycle MultValid / DivValid carrying
//   the result in the same cycle. There is no ready/backpressure: the master
//   launches at most one operation and waits for its Valid before the next.
//   Modports:
//     master : HI/LO unit side (drives operands and launch pulses)
//     slave  : engine side (drives valids and results)
// -----------------------------------------------------------------------------
interface hilo_if #(
   parameter int WIDTH = 32
) ();

   logic [WIDTH-1:0] MultA;
   logic [WIDTH-1:0] MultB;
   logic             MultControl;
   logic             MultValid;
   logic [WIDTH-1:0] MultHi;
   logic [WIDTH-1:0] MultLo;
   logic             DivStart;
   logic             DivValid;
   logic [WIDTH-1:0] DivHi;
   logic [WIDTH-1:0] DivLo;

   modport master (
      output MultA, MultB, MultControl, DivStart,
      input  MultValid, MultHi, MultLo, DivValid, DivHi, DivLo
   );

   modport slave (
      input  MultA, MultB, MultControl, DivStart,
      output MultValid, MultHi, MultLo, DivValid, DivHi, DivLo
   );

endinterface

// File: rtl/hilo_watchdog.sv
// -----------------------------------------------------------------------------
// hilo_watchdog
//   Cycle counter for the WAIT states of hilo_unit. Counts while run is high,
//   clears whenever run is low or it has just expired. expire is high in the
//   TIMEOUT-th consecutive cycle of run, so the owner leaves WAIT on that edge.
//   Ports:
//     clk    in  clock
//     rst_n  in  asynchronous active-low reset
//     run    in  count enable; low clears the counter
//     expire out combinational, one cycle, limit reached
// -----------------------------------------------------------------------------
module hilo_watchdog
   import hilo_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic expire
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt;

   assign expire = run && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!run || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//   Owner of the architectural HI/LO pair. Launches the multiplier or divider,
//   waits for the result and commits it; serves mthi/mtlo writes in IDLE.
//   Optional watchdog: define HILO_TIMEOUT_EN to add parameter TIMEOUT, the
//   hilo_watchdog instance and the TimeoutErr output.
//   Ports:
//     Clk, Reset         clock, asynchronous active-low reset
//     MultReq, DivReq    operation requests (IDLE only), OpA/OpB operands
//     MthiWe, MtloWe     HI/LO writes of WrData (IDLE only)
//     eng                engine bus (master side of hilo_if)
//     Hi, Lo             architectural HI/LO
//     Busy               operation in flight (state != IDLE)
//     DivZero            one-cycle flag: divide by zero rejected
//     TimeoutErr         one-cycle flag: WAIT abandoned (HILO_TIMEOUT_EN only)
//     state              current FSM state, for debug/checkers
// -----------------------------------------------------------------------------
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
`ifdef HILO_TIMEOUT_EN
   , parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             MultReq,
   input  logic             DivReq,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic             MthiWe,
   input  logic             MtloWe,
   input  logic [WIDTH-1:0] WrData,
   hilo_if.master           eng,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             DivZero,
`ifdef HILO_TIMEOUT_EN
   output logic             TimeoutErr,
`endif
   output st_t              state
);

   st_t              state_q, state_nxt;
   logic [WIDTH-1:0] hi_q, hi_nxt;
   logic [WIDTH-1:0] lo_q, lo_nxt;
   logic [WIDTH-1:0] a_q, a_nxt;
   logic [WIDTH-1:0] b_q, b_nxt;
   logic             mctl_q, mctl_nxt;
   logic             dstart_q, dstart_nxt;
   logic             dzero_q, dzero_nxt;
   logic             terr_q, terr_nxt;
   logic             expire;

`ifdef HILO_TIMEOUT_EN
   hilo_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (Clk),
      .rst_n  (Reset),
      .run    (state_q != IDLE),
      .expire (expire)
   );
   assign TimeoutErr = terr_q;
`else
   // Without the watchdog WAIT states hold until the engine answers.
   assign expire = 1'b0;
`endif

   // Next-state and datapath
   always_comb begin
      state_nxt  = state_q;
      hi_nxt     = hi_q;
      lo_nxt     = lo_q;
      a_nxt      = a_q;
      b_nxt      = b_q;
      mctl_nxt   = 1'b0;
      dstart_nxt = 1'b0;
      dzero_nxt  = 1'b0;
      terr_nxt   = 1'b0;

      case (state_q)
         IDLE: begin
            // mthi/mtlo land first; a launched result overwrites them later.
            if (MthiWe) hi_nxt = WrData;
            if (MtloWe) lo_nxt = WrData;
            if (MultReq) begin
               // Multiply has priority; a simultaneous DivReq is dropped.
               a_nxt     = OpA;
               b_nxt     = OpB;
               mctl_nxt  = 1'b1;
               state_nxt = MUL_WAIT;
            end else if (DivReq) begin
               if (OpB == '0) begin
                  dzero_nxt = 1'b1;
               end else begin
                  a_nxt      = OpA;
                  b_nxt      = OpB;
                  dstart_nxt = 1'b1;
                  state_nxt  = DIV_WAIT;
               end
            end
         end
         MUL_WAIT: begin
            if (eng.MultValid) begin
               hi_nxt    = eng.MultHi;
               lo_nxt    = eng.MultLo;
               state_nxt = IDLE;
            end else if (expire) begin
               terr_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         DIV_WAIT: begin
            if (eng.DivValid) begin
               hi_nxt    = eng.DivHi;
               lo_nxt    = eng.DivLo;
               state_nxt = IDLE;
            end else if (expire) begin
               terr_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         mctl_q   <= 1'b0;
         dstart_q <= 1'b0;
         dzero_q  <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         hi_q     <= hi_nxt;
         lo_q     <= lo_nxt;
         a_q      <= a_nxt;
         b_q      <= b_nxt;
         mctl_q   <= mctl_nxt;
         dstart_q <= dstart_nxt;
         dzero_q  <= dzero_nxt;
         terr_q   <= terr_nxt;
      end
   end

   assign eng.MultA       = a_q;
   assign eng.MultB       = b_q;
   assign eng.MultControl = mctl_q;
   assign eng.DivStart    = dstart_q;
   assign Hi              = hi_q;
   assign Lo              = lo_q;
   // Busy falls on the commit edge, together with the HI/LO update.
   assign Busy            = (state_q != IDLE);
   assign DivZero         = dzero_q;
   assign state           = state_q;

`ifndef HILO_TIMEOUT_EN
   // terr_q only reaches a port in watchdog builds.
   logic unused_terr;
   assign unused_terr = terr_q;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int W  = 32;
  localparam int TO = 8;

  // clock / reset
  logic clk;
  logic Reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         MultReq, DivReq, MthiWe, MtloWe;
  logic [W-1:0] OpA, OpB, WrData;
  logic [W-1:0] Hi, Lo;
  logic         Busy, DivZero;
  st_t          dbg_state;
`ifdef HILO_TIMEOUT_EN
  logic         TimeoutErr;
`endif

  hilo_if #(.WIDTH(W)) eng ();

  hilo_unit #(
    .WIDTH (W)
`ifdef HILO_TIMEOUT_EN
    , .TIMEOUT (TO)
`endif
  ) dut (
    .Clk        (clk),
    .Reset      (Reset),
    .MultReq    (MultReq),
    .DivReq     (DivReq),
    .OpA        (OpA),
    .OpB        (OpB),
    .MthiWe     (MthiWe),
    .MtloWe     (MtloWe),
    .WrData     (WrData),
    .eng        (eng.master),
    .Hi         (Hi),
    .Lo         (Lo),
    .Busy       (Busy),
    .DivZero    (DivZero),
`ifdef HILO_TIMEOUT_EN
    .TimeoutErr (TimeoutErr),
`endif
    .state      (dbg_state)
  );

  // scoreboard
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi, m_lo;
  int             n_tests = 0;
  int             n_fail  = 0;

  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", tag, {Hi, Lo});
    end else begin
      e = exp_q.pop_front();
      chk(tag, {Hi, Lo}, e);
    end
  endtask

  // driver tasks (called right after a falling edge)
  task automatic idle_inputs();
    MultReq = 0; DivReq = 0; MthiWe = 0; MtloWe = 0;
    OpA = '0; OpB = '0; WrData = '0;
    eng.MultValid = 0; eng.MultHi = '0; eng.MultLo = '0;
    eng.DivValid = 0; eng.DivHi = '0; eng.DivLo = '0;
  endtask

  task automatic hilo_write(input logic we_hi, input logic we_lo, input logic [W-1:0] d);
    MthiWe = we_hi; MtloWe = we_lo; WrData = d;
    if (we_hi) m_hi = d;
    if (we_lo) m_lo = d;
    exp_q.push_back({m_hi, m_lo});
    @(negedge clk);
    MthiWe = 0; MtloWe = 0;
    pop_check("mthi_mtlo");
  endtask

  task automatic run_op(input logic is_div, input logic [W-1:0] a, b, rh, rl, input int dly);
    int mc, ds, bc;
    mc = 0; ds = 0; bc = 0;
    MultReq = !is_div; DivReq = is_div; OpA = a; OpB = b;
    exp_q.push_back({rh, rl});
    for (int i = 1; i <= dly; i++) begin
      @(negedge clk);
      MultReq = 0; DivReq = 0;
      if (i == 1) begin
        chk("op_a", eng.MultA, a);
        chk("op_b", eng.MultB, b);
        chk("wait_state", dbg_state, is_div ? DIV_WAIT : MUL_WAIT);
      end
      mc += eng.MultControl; ds += eng.DivStart; bc += Busy;
      if (i == dly) begin
        if (is_div) begin eng.DivValid = 1; eng.DivHi = rh; eng.DivLo = rl; end
        else begin eng.MultValid = 1; eng.MultHi = rh; eng.MultLo = rl; end
      end
    end
    @(negedge clk);
    eng.MultValid = 0; eng.DivValid = 0;
    mc += eng.MultControl; ds += eng.DivStart; bc += Busy;
    m_hi = rh; m_lo = rl;
    pop_check(is_div ? "div_commit" : "mult_commit");
    chk("mult_pulses", mc, is_div ? 0 : 1);
    chk("div_pulses", ds, is_div ? 1 : 0);
    chk("busy_cycles", bc, dly);
  endtask

  initial begin
    int mc, ds;
    logic [W-1:0] ra, rb, rh, rl;
    idle_inputs();
    m_hi = '0; m_lo = '0;
    Reset = 0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_hilo", {Hi, Lo}, '0);
    chk("rst_busy", Busy, 0);
    chk("rst_divzero", DivZero, 0);
    chk("rst_ops", {eng.MultA, eng.MultB}, '0);
    chk("rst_pulses", {eng.MultControl, eng.DivStart}, '0);
    chk("rst_state", dbg_state, IDLE);
    Reset = 1;
    @(negedge clk);

    // mthi / mtlo in IDLE
    hilo_write(1, 0, 32'hA5A5A5A5);
    hilo_write(1, 1, 32'h3C3C3C3C);
    hilo_write(0, 1, 32'h0F0F0F0F);

    // reset in the middle of MUL_WAIT, late MultValid ignored
    MultReq = 1; OpA = 32'd1; OpB = 32'd2;
    @(negedge clk);
    MultReq = 0;
    chk("pre_rst_busy", Busy, 1);
    @(negedge clk);
    Reset = 0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("midrst_hilo", {Hi, Lo}, {m_hi, m_lo});
    chk("midrst_busy", Busy, 0);
    chk("midrst_state", dbg_state, IDLE);
    chk("midrst_ops", {eng.MultA, eng.MultB}, '0);
    @(negedge clk);
    Reset = 1;
    @(negedge clk);
    eng.MultValid = 1; eng.MultHi = 32'hDEADBEEF; eng.MultLo = 32'h12345678;
    @(negedge clk);
    eng.MultValid = 0;
    chk("late_valid_hilo", {Hi, Lo}, {m_hi, m_lo});
    chk("late_valid_state", dbg_state, IDLE);

    // signed multiply 7 * -3
    run_op(0, 32'd7, -32'sd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 3);

    // divide 17 / 5
    run_op(1, 32'd17, 32'd5, 32'd2, 32'd3, 2);

    // divide by zero rejected
    DivReq = 1; OpA = 32'd9; OpB = '0;
    @(negedge clk);
    DivReq = 0;
    chk("dz_flag", DivZero, 1);
    chk("dz_no_start", eng.DivStart, 0);
    chk("dz_busy", Busy, 0);
    chk("dz_hilo", {Hi, Lo}, {m_hi, m_lo});
    @(negedge clk);
    chk("dz_pulse_end", DivZero, 0);

    // mthi while busy is ignored
    MultReq = 1; OpA = 32'd4; OpB = 32'd5;
    exp_q.push_back({32'd0, 32'd20});
    @(negedge clk);
    MultReq = 0; MthiWe = 1; WrData = 32'h12345678;
    @(negedge clk);
    MthiWe = 0;
    chk("busy_mthi_ignored", Hi, m_hi);
    eng.MultValid = 1; eng.MultHi = 32'd0; eng.MultLo = 32'd20;
    @(negedge clk);
    eng.MultValid = 0;
    m_hi = 32'd0; m_lo = 32'd20;
    pop_check("busy_mthi_commit");

    // mthi in the same cycle as MultReq: write lands, result overwrites
    MultReq = 1; OpA = 32'd6; OpB = 32'd6; MthiWe = 1; WrData = 32'hCAFEF00D;
    exp_q.push_back({32'd0, 32'd36});
    @(negedge clk);
    MultReq = 0; MthiWe = 0;
    chk("same_cyc_mthi", Hi, 32'hCAFEF00D);
    chk("same_cyc_busy", Busy, 1);
    eng.MultValid = 1; eng.MultHi = 32'd0; eng.MultLo = 32'd36;
    @(negedge clk);
    eng.MultValid = 0;
    m_hi = 32'd0; m_lo = 32'd36;
    pop_check("same_cyc_commit");

    // MultReq and DivReq together: multiply wins; re-request and DivValid ignored
    MultReq = 1; DivReq = 1; OpA = 32'd3; OpB = 32'd11;
    exp_q.push_back({32'd0, 32'd33});
    mc = 0; ds = 0;
    @(negedge clk);
    MultReq = 0; DivReq = 0;
    mc += eng.MultControl; ds += eng.DivStart;
    chk("both_state", dbg_state, MUL_WAIT);
    MultReq = 1; OpA = 32'd100; OpB = 32'd100;
    eng.DivValid = 1; eng.DivHi = 32'h55; eng.DivLo = 32'h66;
    @(negedge clk);
    MultReq = 0; eng.DivValid = 0;
    mc += eng.MultControl; ds += eng.DivStart;
    chk("wrong_valid_busy", Busy, 1);
    chk("wrong_valid_hilo", {Hi, Lo}, {m_hi, m_lo});
    chk("rereq_ops", eng.MultA, 32'd3);
    eng.MultValid = 1; eng.MultHi = 32'd0; eng.MultLo = 32'd33;
    @(negedge clk);
    eng.MultValid = 0;
    mc += eng.MultControl; ds += eng.DivStart;
    m_hi = 32'd0; m_lo = 32'd33;
    pop_check("both_commit");
    eng.MultValid = 1; eng.MultHi = 32'h77; eng.MultLo = 32'h88;
    @(negedge clk);
    eng.MultValid = 0;
    mc += eng.MultControl; ds += eng.DivStart;
    chk("both_mult_pulses", mc, 1);
    chk("both_div_pulses", ds, 0);
    chk("idle_valid_hilo", {Hi, Lo}, {m_hi, m_lo});
    chk("idle_valid_busy", Busy, 0);

    // random operations
    for (int k = 0; k < 8; k++) begin
      ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
      if (rb == '0) rb = 32'd1;
      run_op($urandom_range(0, 1) == 1, ra, rb, rh, rl, $urandom_range(1, 5));
    end

`ifdef HILO_TIMEOUT_EN
    // watchdog: no Valid -> TimeoutErr after TO cycles, HI/LO unchanged
    begin
      int bc, tc, tidx;
      bc = 0; tc = 0; tidx = 0;
      MultReq = 1; OpA = 32'd2; OpB = 32'd2;
      for (int i = 1; i <= TO + 3; i++) begin
        @(negedge clk);
        MultReq = 0;
        bc += Busy;
        if (TimeoutErr) begin tc++; tidx = i; end
      end
      chk("to_busy_cycles", bc, TO);
      chk("to_pulses", tc, 1);
      chk("to_when", tidx, TO + 1);
      chk("to_hilo", {Hi, Lo}, {m_hi, m_lo});
      chk("to_state", dbg_state, IDLE);
    end
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
